// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// The master is the byte source; the slave is the loader.
interface imem_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words and writes them to
// instruction memory from address 0. Holds the core in reset until a checksummed image lands.
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  imem_loader_if.slave      byte_if,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst_f,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        idx_q;
  logic [7:0]        acc_q;
  logic [23:0]       pack_q;
  logic              byte_ready_q;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
  logic              core_rst_f_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              accept;
  logic [7:0]        acc_d;
  logic [31:0]       word_d;
  logic [ADDR_W-1:0] last_addr;

  assign accept    = byte_if.byte_valid && byte_ready_q;
  assign acc_d     = acc_q + byte_if.byte_in;
  assign word_d    = {pack_q, byte_if.byte_in};
  assign last_addr = count_q - ADDR_W'(1);

  // NOTE: state registers use non-blocking assignments and reset asynchronously so every
  // output is at its safe value the instant rst_f falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      idx_q        <= '0;
      acc_q        <= '0;
      pack_q       <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_rst_f_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            count_q      <= word_count;
            addr_q       <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            byte_ready_q <= 1'b1;
            core_rst_f_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= (word_count == '0) ? S_CHECK : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            acc_q  <= acc_d;
            idx_q  <= idx_q + 2'd1;
            pack_q <= {pack_q[15:0], byte_if.byte_in};
            // The fourth byte completes a word; the write overlaps acceptance of the next byte.
            if (idx_q == 2'd3) begin
              im_we_q    <= 1'b1;
              im_addr_q  <= addr_q;
              im_wdata_q <= word_d;
              addr_q     <= addr_q + ADDR_W'(1);
              if (addr_q == last_addr) state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            if (acc_d == 8'h00) begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_rst_f_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_if.byte_ready = byte_ready_q;
  assign im_we              = im_we_q;
  assign im_addr            = im_addr_q;
  assign im_wdata           = im_wdata_q;
  assign core_rst_f         = core_rst_f_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven image loads with a write scoreboard,
// plus hand-written reset-abort and start-while-busy sequences.
module tb_imem_loader;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst_f;
  logic              start;
  logic [ADDR_W-1:0] word_count;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              core_rst_f;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader_if byte_if ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .byte_if    (byte_if.slave),
    .start      (start),
    .word_count (word_count),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_rst_f (core_rst_f),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_writes = 0;
  int seen_writes = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [ADDR_W-1:0] wc;
    logic [1:0][31:0]  words;
    logic [7:0]        chk;
    int                stall;
    logic              exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wr_t e;
      seen_writes++;
      if (wr_q.size() == 0) begin
        check("unexpected_im_we", 1, 0);
      end else begin
        e = wr_q.pop_front();
        check("im_addr", im_addr, e.addr);
        check("im_wdata", im_wdata, e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, byte_if.byte_ready, 0);
    check({tag, "_im_we"}, im_we, 0);
    check({tag, "_im_addr"}, im_addr, 0);
    check({tag, "_im_wdata"}, im_wdata, 0);
    check({tag, "_core_rst_f"}, core_rst_f, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_if.byte_in    = b;
    byte_if.byte_valid = 1'b1;
    while (byte_if.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] addr, input logic [31:0] w, input int stall);
    for (int bi = 0; bi < 4; bi++) begin
      if (bi == 3) begin
        wr_q.push_back('{addr: addr, data: w});
        exp_writes++;
      end
      send_byte(w[31-8*bi -: 8]);
      if (stall > 0) begin
        byte_if.byte_valid = 1'b0;
        repeat (stall) @(negedge clk);
      end
    end
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] wc);
    start      = 1'b1;
    word_count = wc;
    @(negedge clk);
    start      = 1'b0;
    word_count = '1;
    check("start_busy", busy, 1);
    check("start_byte_ready", byte_if.byte_ready, 1);
    check("start_core_rst_f", core_rst_f, 0);
    check("start_done", done, 0);
    check("start_err", err, 0);
  endtask

  task automatic finish_check(input logic [7:0] chk, input logic exp_err);
    send_byte(chk);
    byte_if.byte_valid = 1'b0;
    check("end_done", done, !exp_err);
    check("end_err", err, exp_err);
    check("end_core_rst_f", core_rst_f, !exp_err);
    check("end_byte_ready", byte_if.byte_ready, 0);
    check("end_busy", busy, 0);
    @(negedge clk);
    check("write_count", seen_writes, exp_writes);
  endtask

  vec_t vecs[5];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Checksums make the mod-256 sum of data plus checksum zero (or deliberately not).
    vecs[0] = '{wc: 16'd2, words: {32'h89ABCDEF, 32'h01234567}, chk: 8'h40, stall: 0, exp_err: 1'b0};
    vecs[1] = '{wc: 16'd2, words: {32'h89ABCDEF, 32'h01234567}, chk: 8'h41, stall: 0, exp_err: 1'b1};
    vecs[2] = '{wc: 16'd1, words: {32'h0, 32'hDEADBEEF}, chk: 8'hC8, stall: 3, exp_err: 1'b0};
    vecs[3] = '{wc: 16'd0, words: {32'h0, 32'h0}, chk: 8'h00, stall: 0, exp_err: 1'b0};
    vecs[4] = '{wc: 16'd0, words: {32'h0, 32'h0}, chk: 8'h05, stall: 0, exp_err: 1'b1};

    rst_f              = 1'b0;
    start              = 1'b0;
    word_count         = '0;
    byte_if.byte_in    = '0;
    byte_if.byte_valid = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_f = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    for (int v = 0; v < 5; v++) begin
      start_load(vecs[v].wc);
      for (int w = 0; w < int'(vecs[v].wc); w++)
        send_word(ADDR_W'(w), vecs[v].words[w], vecs[v].stall);
      finish_check(vecs[v].chk, vecs[v].exp_err);
    end

    // Reset after 6 of 8 bytes aborts at once with no further strobe.
    start_load(16'd2);
    send_word(16'd0, 32'h01234567, 0);
    send_byte(8'h89);
    send_byte(8'hAB);
    byte_if.byte_valid = 1'b0;
    #2 rst_f = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    check("midrst_write_count", seen_writes, exp_writes);
    rst_f = 1'b1;
    @(negedge clk);
    start_load(16'd2);
    send_word(16'd0, 32'h01234567, 0);
    send_word(16'd1, 32'h89ABCDEF, 0);
    finish_check(8'h40, 1'b0);

    // A start pulse mid-load must not relatch word_count.
    start_load(16'd1);
    send_byte(8'hCA);
    send_byte(8'hFE);
    byte_if.byte_valid = 1'b0;
    start      = 1'b1;
    word_count = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_busy", busy, 1);
    check("busy_start_ready", byte_if.byte_ready, 1);
    send_byte(8'hF0);
    wr_q.push_back('{addr: 16'd0, data: 32'hCAFEF00D});
    exp_writes++;
    send_byte(8'h0D);
    finish_check(8'h3B, 1'b0);

    // Reload from DONE re-asserts core reset and overwrites address 0.
    start_load(16'd1);
    send_word(16'd0, 32'h13579BDF, 0);
    finish_check(8'h1C, 1'b0);
    check("scoreboard_empty", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
